// File: rtl/ip_tone_gen.sv
// I/O-mapped square-wave tone generator feeding ip_pwm.signal_level.
// Ports: clk/reset/enable, MSX bus slave (4 regs), signal_level, playing.
module ip_tone_gen #(
  parameter logic [7:0] io_address = 8'h10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] bus_address,
  output logic        bus_io_cs,
  output logic        bus_memory_cs,
  output logic        bus_read_ready,
  output logic [7:0]  bus_read_data,
  input  logic [7:0]  bus_write_data,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic        bus_io,
  input  logic        bus_memory,
  output logic [15:0] signal_level,
  output logic        playing
);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t      state;
  state_t      state_n;

  logic [15:0] freq;
  logic [7:0]  level;
  logic [15:0] div_cnt;
  logic        phase;
  logic [9:0]  ms_pre;
  logic [7:0]  dur_cnt;
  logic [7:0]  out_level;
  logic        rd_ready;
  logic [7:0]  rd_data;
  logic [7:0]  rd_mux;

  logic        wr_acc;
  logic        rd_acc;
  logic        wr_dur;
  logic        start;
  logic        tick;
  logic        expire;
  logic [1:0]  reg_sel;
  logic        unused_bits;

  assign unused_bits = ^{bus_memory, bus_address[15:8]};

  assign bus_io_cs = bus_io &
    (bus_address[7:2] == io_address[7:2]);
  assign bus_memory_cs = 1'b0;

  assign reg_sel = bus_address[1:0];
  assign wr_acc  = bus_write & bus_io_cs;
  assign rd_acc  = bus_read & bus_io_cs;
  assign wr_dur  = wr_acc & (reg_sel == 2'd3);
  assign start   = wr_dur & (bus_write_data != 8'h00);
  assign tick    = (state == PLAY) & enable;

  // Last millisecond of a finite duration elapses on this tick.
  assign expire = tick & (ms_pre == 10'd0) &
    (dur_cnt != 8'hFF) & (dur_cnt == 8'd1);

  always_comb begin
    state_n = state;
    if (wr_dur) begin
      state_n = start ? PLAY : IDLE;
    end else if (expire) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (reg_sel)
      2'd0:    rd_mux = freq[7:0];
      2'd1:    rd_mux = freq[15:8];
      2'd2:    rd_mux = level;
      default: rd_mux = {7'd0, playing};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      freq      <= 16'h0000;
      level     <= 8'h00;
      div_cnt   <= 16'h0000;
      phase     <= 1'b0;
      ms_pre    <= 10'd999;
      dur_cnt   <= 8'h00;
      out_level <= 8'h00;
      rd_ready  <= 1'b0;
      rd_data   <= 8'h00;
    end else begin
      if (wr_acc) begin
        case (reg_sel)
          2'd0:    freq[7:0]  <= bus_write_data;
          2'd1:    freq[15:8] <= bus_write_data;
          2'd2:    level      <= bus_write_data;
          default: ;
        endcase
      end

      // A DUR write beats any tick in the same cycle.
      if (start) begin
        div_cnt <= freq;
        phase   <= 1'b1;
        ms_pre  <= 10'd999;
        dur_cnt <= bus_write_data;
      end else if (tick) begin
        if (div_cnt == 16'h0000) begin
          phase   <= ~phase;
          div_cnt <= freq;
        end else begin
          div_cnt <= div_cnt - 16'd1;
        end
        if (ms_pre == 10'd0) begin
          ms_pre <= 10'd999;
          if (dur_cnt != 8'hFF) begin
            dur_cnt <= dur_cnt - 8'd1;
          end
        end else begin
          ms_pre <= ms_pre - 10'd1;
        end
      end

      // Silence immediately on stop; sound one cycle after start.
      if ((state == PLAY) && (state_n == PLAY) &&
          phase && (freq != 16'h0000)) begin
        out_level <= level;
      end else begin
        out_level <= 8'h00;
      end

      rd_ready <= rd_acc;
      rd_data  <= rd_acc ? rd_mux : 8'h00;
    end
  end

  assign playing        = (state == PLAY);
  assign signal_level   = {out_level, 8'h00};
  assign bus_read_ready = rd_ready;
  assign bus_read_data  = rd_data;

endmodule

// File: tb/tb_ip_tone_gen.sv
// Self-checking bench for ip_tone_gen: bus vector table,
// directed tone/duration corners and randomized sessions vs a model.
module tb_ip_tone_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] bus_address;
  logic        bus_io_cs;
  logic        bus_memory_cs;
  logic        bus_read_ready;
  logic [7:0]  bus_read_data;
  logic [7:0]  bus_write_data;
  logic        bus_read;
  logic        bus_write;
  logic        bus_io;
  logic        bus_memory;
  logic [15:0] signal_level;
  logic        playing;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ip_tone_gen #(.io_address(8'h10)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .bus_address   (bus_address),
    .bus_io_cs     (bus_io_cs),
    .bus_memory_cs (bus_memory_cs),
    .bus_read_ready(bus_read_ready),
    .bus_read_data (bus_read_data),
    .bus_write_data(bus_write_data),
    .bus_read      (bus_read),
    .bus_write     (bus_write),
    .bus_io        (bus_io),
    .bus_memory    (bus_memory),
    .signal_level  (signal_level),
    .playing       (playing)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] a;
    logic        io;
    logic [7:0]  d;
    logic        cs;
    logic        rdy;
    logic [7:0]  q;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic wr, input logic rd,
                     input logic [15:0] a, input logic io,
                     input logic [7:0] d, input logic en);
    bus_address    = a;
    bus_io         = io;
    bus_memory     = ~io;
    bus_write      = wr;
    bus_read       = rd;
    bus_write_data = d;
    enable         = en;
    cyc();
    bus_write  = 1'b0;
    bus_read   = 1'b0;
    bus_io     = 1'b0;
    bus_memory = 1'b0;
    enable     = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a,
                        input logic [7:0] exp);
    acc(1'b0, 1'b1, a, 1'b1, 8'h00, 1'b0);
    chk({name, "_rdy"}, 32'(bus_read_ready), 32'd1);
    chk(name, 32'(bus_read_data), 32'(exp));
  endtask

  // Reference: half period is f+1 ticks, starting high.
  function automatic logic ph(input int n, input int f);
    return ((n / (f + 1)) % 2) == 0;
  endfunction

  function automatic logic pl(input int n, input int d);
    return (d == 255) || (n < d * 1000);
  endfunction

  task automatic start(input int f, input int l, input int d);
    acc(1'b1, 1'b0, 16'h0010, 1'b1, 8'(f), 1'b0);
    acc(1'b1, 1'b0, 16'h0011, 1'b1, 8'(f >> 8), 1'b0);
    acc(1'b1, 1'b0, 16'h0012, 1'b1, 8'(l), 1'b0);
    acc(1'b1, 1'b0, 16'h0013, 1'b1, 8'(d), 1'b0);
    chk("start_playing", 32'(playing), 32'd1);
  endtask

  // Session began at the previous edge with zero ticks seen.
  task automatic run(input int f, input int l, input int d,
                     input int cycles, input bit rnd,
                     input string tag);
    int nb;
    int na;
    logic en;
    logic ep;
    logic [15:0] es;
    nb = 0;
    for (int i = 0; i < cycles; i++) begin
      en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      enable = en;
      cyc();
      enable = 1'b0;
      na = nb + int'(en);
      ep = pl(na, d);
      es = (ep && f != 0 && ph(nb, f)) ?
           {8'(l), 8'h00} : 16'h0000;
      chk({tag, "_playing"}, 32'(playing), 32'(ep));
      chk({tag, "_level"}, 32'(signal_level), 32'(es));
      nb = na;
    end
  endtask

  initial begin
    logic e5;
    reset          = 1'b1;
    enable         = 1'b0;
    bus_address    = 16'h0000;
    bus_write_data = 8'h00;
    bus_read       = 1'b0;
    bus_write      = 1'b0;
    bus_io         = 1'b0;
    bus_memory     = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;

    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_level", 32'(signal_level), 32'd0);
    chk("rst_rdy", 32'(bus_read_ready), 32'd0);
    chk("rst_rdata", 32'(bus_read_data), 32'd0);

    tv.push_back('{1'b0,1'b1,16'h0010,1'b1,8'h00,1'b1,1'b1,8'h00});
    tv.push_back('{1'b0,1'b0,16'h0010,1'b0,8'h00,1'b0,1'b0,8'h00});
    tv.push_back('{1'b0,1'b1,16'h0011,1'b1,8'h00,1'b1,1'b1,8'h00});
    tv.push_back('{1'b0,1'b1,16'h0012,1'b1,8'h00,1'b1,1'b1,8'h00});
    tv.push_back('{1'b0,1'b1,16'h0013,1'b1,8'h00,1'b1,1'b1,8'h00});
    tv.push_back('{1'b1,1'b0,16'h0010,1'b1,8'hF3,1'b1,1'b0,8'h00});
    tv.push_back('{1'b1,1'b0,16'h0011,1'b1,8'h01,1'b1,1'b0,8'h00});
    tv.push_back('{1'b1,1'b0,16'h0012,1'b1,8'h80,1'b1,1'b0,8'h00});
    tv.push_back('{1'b0,1'b1,16'h0010,1'b1,8'h00,1'b1,1'b1,8'hF3});
    tv.push_back('{1'b0,1'b1,16'h0011,1'b1,8'h00,1'b1,1'b1,8'h01});
    tv.push_back('{1'b0,1'b1,16'h0012,1'b1,8'h00,1'b1,1'b1,8'h80});
    tv.push_back('{1'b0,1'b0,16'h0012,1'b0,8'h00,1'b0,1'b0,8'h00});
    tv.push_back('{1'b1,1'b0,16'h0014,1'b1,8'h55,1'b0,1'b0,8'h00});
    tv.push_back('{1'b0,1'b1,16'h0014,1'b1,8'h00,1'b0,1'b0,8'h00});
    tv.push_back('{1'b1,1'b0,16'h0010,1'b0,8'h77,1'b0,1'b0,8'h00});
    tv.push_back('{1'b0,1'b1,16'h0010,1'b0,8'h00,1'b0,1'b0,8'h00});
    tv.push_back('{1'b0,1'b1,16'h000F,1'b1,8'h00,1'b0,1'b0,8'h00});
    tv.push_back('{1'b0,1'b1,16'h0010,1'b1,8'h00,1'b1,1'b1,8'hF3});
    tv.push_back('{1'b0,1'b1,16'h0013,1'b1,8'h00,1'b1,1'b1,8'h00});

    foreach (tv[i]) begin
      bus_address    = tv[i].a;
      bus_io         = tv[i].io;
      bus_memory     = ~tv[i].io;
      bus_write      = tv[i].wr;
      bus_read       = tv[i].rd;
      bus_write_data = tv[i].d;
      #1;
      chk($sformatf("tv%0d_cs", i), 32'(bus_io_cs), 32'(tv[i].cs));
      chk($sformatf("tv%0d_mcs", i), 32'(bus_memory_cs), 32'd0);
      cyc();
      bus_write  = 1'b0;
      bus_read   = 1'b0;
      bus_io     = 1'b0;
      bus_memory = 1'b0;
      chk($sformatf("tv%0d_rdy", i), 32'(bus_read_ready),
          32'(tv[i].rdy));
      chk($sformatf("tv%0d_q", i), 32'(bus_read_data),
          32'(tv[i].q));
      chk($sformatf("tv%0d_lvl", i), 32'(signal_level), 32'd0);
    end

    start(499, 8'h80, 255);
    run(499, 8'h80, 255, 5000, 1'b0, "cont");

    start(99, 8'hFF, 3);
    run(99, 8'hFF, 3, 3005, 1'b0, "dur3");
    rd_chk("dur3_status", 16'h0013, 8'h00);

    start(20, 8'h33, 255);
    run(20, 8'h33, 255, 50, 1'b0, "stop");
    acc(1'b1, 1'b0, 16'h0013, 1'b1, 8'h00, 1'b0);
    chk("stop_playing", 32'(playing), 32'd0);
    chk("stop_level", 32'(signal_level), 32'd0);

    start(20, 8'h33, 255);
    run(20, 8'h33, 255, 30, 1'b0, "prerst");
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_mid_playing", 32'(playing), 32'd0);
    chk("rst_mid_level", 32'(signal_level), 32'd0);
    rd_chk("rst_freq_l", 16'h0010, 8'h00);
    rd_chk("rst_freq_h", 16'h0011, 8'h00);
    rd_chk("rst_lvl", 16'h0012, 8'h00);
    rd_chk("rst_stat", 16'h0013, 8'h00);

    // FREQ write lands on the reload tick: old 9 -> 10 ticks,
    // next half still 10, then 5 with the new value.
    start(9, 8'h40, 255);
    for (int nb = 0; nb < 30; nb++) begin
      if (nb == 9) begin
        acc(1'b1, 1'b0, 16'h0010, 1'b1, 8'd4, 1'b1);
      end else begin
        enable = 1'b1;
        cyc();
        enable = 1'b0;
      end
      e5 = (nb < 10) || (nb >= 20 && nb < 25);
      chk($sformatf("freqwr_n%0d", nb), 32'(signal_level),
          e5 ? 32'h4000 : 32'h0);
    end

    start(5, 8'h11, 1);
    run(5, 8'h11, 1, 999, 1'b0, "pre_exp");
    acc(1'b1, 1'b0, 16'h0013, 1'b1, 8'd2, 1'b1);
    chk("exp_wr_playing", 32'(playing), 32'd1);
    run(5, 8'h11, 2, 2003, 1'b0, "post_exp");

    for (int s = 0; s < 6; s++) begin
      int f;
      int l;
      int d;
      f = int'($urandom_range(0, 60));
      l = int'($urandom_range(0, 255));
      d = (s % 2 == 1) ? 255 : 1;
      start(f, l, d);
      run(f, l, d, (d == 1) ? 2300 : 600, 1'b1,
          $sformatf("rnd%0d", s));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ip_tone_gen.md
# ip_tone_gen

I/O-mapped square-wave tone generator that replaces the hard-coded scale sequencer in front of `ip_pwm`. It sits on the internal MSX bus next to `ip_gpio`, whose read data and chip-selects are OR-merged. The CPU programs the divider, amplitude and duration through four I/O ports. The block emits a 16-bit `signal_level` that drives `ip_pwm.signal_level` directly, using the same 1 MHz enable strobe.

## Interface
- `io_address`, default 8'h10, base I/O port; occupies `io_address` … `io_address+3` (aligned to 4; bits [1:0] ignored).
- `clk`  in  1  system clock (53.685 MHz)
- `reset`  in  1  synchronous reset, active-high
- `enable`  in  1  1 MHz tick, one-cycle pulse
- `bus_address`  in  16  bus address
- `bus_io_cs`  out  1  I/O chip-select for this block
- `bus_memory_cs`  out  1  memory chip-select, tied 0
- `bus_read_ready`  out  1  read-data-valid pulse
- `bus_read_data`  out  8  read data; 8'h00 when not `bus_read_ready`
- `bus_write_data`  in  8  write data
- `bus_read`  in  1  read strobe, one cycle
- `bus_write`  in  1  write strobe, one cycle
- `bus_io`  in  1  current cycle is I/O
- `bus_memory`  in  1  current cycle is memory, unused
- `signal_level`  out  16  PWM level: {`out_level`, 8'h00}
- `playing`  out  1  tone active

## Operation
- `bus_io_cs` is combinational: `bus_io & (bus_address[7:2] == io_address[7:2])`.
- Registers are indexed by `bus_address[1:0]`:
  - 0: FREQ_L (R/W)
  - 1: FREQ_H (R/W). FREQ = {H,L} is the half-period in 1 MHz ticks.
  - 2: LEVEL (R/W), amplitude 0–255.
  - 3, write: DUR.
    - 8'h00 stops the tone.
    - 8'hFF plays continuously.
    - 1–254 plays for DUR ms.
  - 3, read: {7'd0, `playing`}.
- Write is accepted when `bus_write & bus_io_cs`. The register updates on the next clk edge.
- Read is accepted when `bus_read & bus_io_cs`. Next cycle: `bus_read_ready`=1 for exactly one cycle with the data. All other cycles: `bus_read_ready`=0 and `bus_read_data`=8'h00.
- State machine has two states, IDLE and PLAY.
  - IDLE → PLAY: write of DUR ≠ 0.
  - PLAY → IDLE:
    - write of DUR = 0, or
    - duration expiry (DUR 1–254 only), or
    - reset.
  - A DUR write while in PLAY restarts the tone with the new duration.
- On entering or restarting PLAY:
  - `div_cnt` ← FREQ
  - `phase` ← 1
  - `ms_pre` ← 999
  - `dur_cnt` ← DUR
- Tone generation, in PLAY on `enable`:
  - If `div_cnt`==0: `phase` toggles and `div_cnt` ← FREQ (the current register value, so FREQ writes take effect at the next reload).
  - Otherwise `div_cnt` decrements (16-bit, no wrap).
- Output:
  - `out_level` = (PLAY & `phase` & FREQ≠0) ? LEVEL : 0.
  - FREQ=0 in PLAY gives silence but stays in PLAY.
  - Output is registered: it updates the cycle after a `phase`, LEVEL or state change.
- Duration, in PLAY on `enable`:
  - `ms_pre` decrements 999→0, then reloads to 999.
  - When `ms_pre`==0 and DUR≠FF: `dur_cnt` decrements.
  - When `dur_cnt` reaches 0 → IDLE. A 1 ms step therefore lasts exactly 1000 `enable` pulses.
- `playing` = (state==PLAY), registered.

## Timing
- Reset values:
  - `bus_read_ready`=0, `bus_read_data`=8'h00
  - `signal_level`=16'h0000, `playing`=0
  - FREQ=0, LEVEL=0, DUR=0, state IDLE
  - `div_cnt`=0, `phase`=0, `ms_pre`=999, `dur_cnt`=0
- Reset mid-play: the next cycle shows `signal_level`=0 and `playing`=0.
- Write latency: register valid 1 clk after the strobe. `playing` rises 1 clk after a DUR write. The first non-zero `signal_level` appears 1 clk after `playing` (`phase`=1 at start).
- Read latency: exactly 1 clk.
- Simultaneous DUR write and expiry: the write wins (restart / new state).
- Simultaneous FREQ write and reload on `enable`: the reload uses the old FREQ.
- Period: a full square period is 2·(FREQ+1) `enable` ticks.
- `bus_write` while `bus_io_cs`=0: ignored. `bus_memory` cycles: ignored.

## Test plan
1. Reset, then read ports 10h–13h → each returns `bus_read_ready` one clk after `bus_read`; data 00,00,00,00; `signal_level`=0.
2. Write FREQ=499 (L=F3h, H=01h), LEVEL=80h, DUR=FFh; run 5000 `enable` ticks → `signal_level` alternates 8000h/0000h every 500 ticks; `playing`=1 throughout.
3. FREQ=99, LEVEL=FFh, DUR=3 → `playing` falls exactly 3000 `enable` ticks after the start; `signal_level`=0 after; read 13h returns 00h.
4. While playing with DUR=FFh, write DUR=00h → `playing`=0 and `signal_level`=0 one clk later. Assert `reset` mid-play → same result, and registers read back 00h.
5. While playing, write FREQ on the same clk as a reload `enable` → old half-period completes, new half-period is used from the following reload. Write DUR=2 on the same clk as DUR=1 expiry → stays PLAY for a further 2000 ticks.
6. Access port 14h and memory cycles at 0010h → `bus_io_cs`=0, no `bus_read_ready`, registers unchanged.
